// File: rtl/datamem_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported datamem word RAM.
// Define DATAMEM_ARB_RR_EN for round-robin arbitration; fixed A-priority otherwise.
module datamem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              a_ack_q, a_ack_d, a_err_q, a_err_d;
    logic              b_ack_q, b_ack_d, b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic              sel_a;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_aligned;
    logic [DATA_W-1:0] cap_data;

`ifdef DATAMEM_ARB_RR_EN
    logic last_q, last_d;  // 1 = B won the most recent arbitration

    always_comb sel_a = a_req & (~b_req | last_q);
`else
    always_comb sel_a = a_req;
`endif

    always_comb begin
        req_we      = sel_a ? a_we    : b_we;
        req_addr    = sel_a ? a_addr  : b_addr;
        req_wdata   = sel_a ? a_wdata : b_wdata;
        req_aligned = (req_addr[1:0] == 2'b00);
        // memRead is only high for aligned loads, so stores/misaligned capture 0
        cap_data    = mem_read_q ? mem_readData : '0;
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        mem_address_d    = '0;
        mem_write_data_d = '0;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        a_ack_d          = 1'b0;
        a_err_d          = 1'b0;
        b_ack_d          = 1'b0;
        b_err_d          = 1'b0;
        a_rdata_d        = a_rdata_q;
        b_rdata_d        = b_rdata_q;
`ifdef DATAMEM_ARB_RR_EN
        last_d           = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    state_d          = StAccess;
                    grant_d          = {~sel_a, sel_a};
                    mem_address_d    = req_addr;
                    mem_write_data_d = req_wdata;
                    mem_write_d      = req_we & req_aligned;
                    mem_read_d       = ~req_we & req_aligned;
`ifdef DATAMEM_ARB_RR_EN
                    last_d           = ~sel_a;
`endif
                end
            end
            StAccess: begin
                state_d = StResp;
                if (grant_q[0]) begin
                    a_ack_d   = 1'b1;
                    a_err_d   = |mem_address_q[1:0];
                    a_rdata_d = cap_data;
                end else begin
                    b_ack_d   = 1'b1;
                    b_err_d   = |mem_address_q[1:0];
                    b_rdata_d = cap_data;
                end
            end
            StResp: begin
                state_d = StIdle;
                grant_d = '0;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            grant_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            a_ack_q          <= 1'b0;
            a_err_q          <= 1'b0;
            b_ack_q          <= 1'b0;
            b_err_q          <= 1'b0;
            a_rdata_q        <= '0;
            b_rdata_q        <= '0;
`ifdef DATAMEM_ARB_RR_EN
            last_q           <= 1'b1;
`endif
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            a_ack_q          <= a_ack_d;
            a_err_q          <= a_err_d;
            b_ack_q          <= b_ack_d;
            b_err_q          <= b_err_d;
            a_rdata_q        <= a_rdata_d;
            b_rdata_q        <= b_rdata_d;
`ifdef DATAMEM_ARB_RR_EN
            last_q           <= last_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_write_data_q;
    assign mem_memWrite  = mem_write_q;
    assign mem_memRead   = mem_read_q;
    assign a_ack         = a_ack_q;
    assign a_err         = a_err_q;
    assign a_rdata       = a_rdata_q;
    assign b_ack         = b_ack_q;
    assign b_err         = b_err_q;
    assign b_rdata       = b_rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a small behavioural datamem model.
module tb_datamem_arbiter;

    logic        clock, reset_n;
    logic        a_req, a_we, a_ack, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fails  = 0;

    datamem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData), .grant(grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // datamem model: word i initialised to 0xA0000000 + i, combinational read
    logic [31:0] ram [0:63];
    logic        ram_init = 1'b0;
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hA000_0000 + i;
            ram_init <= 1'b1;
        end else if (mem_memWrite) begin
            ram[mem_address[7:2]] <= mem_writeData;
        end
    end
    assign mem_readData = ram[mem_address[7:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One access on a single port; checks ACCESS-cycle memory drive and ack timing
    task automatic run_access(input string tag, input bit pb, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
        int  lat;
        bit  aligned;
        logic ack;
        aligned = (addr[1:0] == 2'b00);
        lat = 0;
        @(negedge clock);
        if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clock);
            if (i == 1) begin
                check_eq({tag, "_memWrite"}, 32'(mem_memWrite), 32'(we & aligned));
                check_eq({tag, "_memRead"}, 32'(mem_memRead), 32'(~we & aligned));
                check_eq({tag, "_grant"}, 32'(grant), pb ? 32'd2 : 32'd1);
                if (aligned) check_eq({tag, "_addr"}, mem_address, addr);
            end
            ack = pb ? b_ack : a_ack;
            if (ack) lat = i;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd2);
        check_eq({tag, "_memWrite_resp"}, 32'(mem_memWrite), 32'd0);
        check_eq({tag, "_err"}, 32'(pb ? b_err : a_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, pb ? b_rdata : a_rdata, exp_rdata);
        if (pb) b_req = 1'b0; else a_req = 1'b0;
    endtask

    int a_cnt, b_cnt, a_first, b_first, a_second;

    initial begin
        reset_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge clock);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        check_eq("rst_mem", 32'({mem_memWrite, mem_memRead}), 32'd0);
        check_eq("rst_addr", mem_address, 32'd0);
        check_eq("rst_rdata", a_rdata | b_rdata, 32'd0);
        reset_n = 1'b1;

        run_access("a_st08", 1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_access("a_ld08", 1'b0, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_access("a_ld06", 1'b0, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1);
        run_access("a_st0a", 1'b0, 1'b1, 32'h0A, 32'h5555_5555, 32'h0, 1'b1);
        check_eq("ram_w1_kept", ram[1], 32'hA000_0001);
        run_access("a_ld08b", 1'b0, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // B store 0x10, A load of 0x10 arrives one cycle later
        @(negedge clock);
        b_req = 1; b_we = 1; b_addr = 32'h10; b_wdata = 32'h1234_5678;
        a_first = 0; b_first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 1) begin a_req = 1; a_we = 0; a_addr = 32'h10; end
            if (b_ack && b_first == 0) begin b_first = i; b_req = 0; end
            if (a_ack && a_first == 0) begin a_first = i; a_req = 0; end
        end
        check_eq("bA_b_ack_cyc", 32'(b_first), 32'd2);
        check_eq("bA_a_ack_cyc", 32'(a_first), 32'd5);
        check_eq("bA_a_rdata", a_rdata, 32'h1234_5678);
        check_eq("bA_b_rdata", b_rdata, 32'h0);

        run_access("b_ld08", 1'b1, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0);
        check_eq("a_rdata_hold", a_rdata, 32'h1234_5678);

        // A holds req one cycle past ack: second access follows
        @(negedge clock);
        a_req = 1; a_we = 0; a_addr = 32'h04;
        a_cnt = 0; a_first = 0; a_second = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 4) a_req = 0;
            if (a_ack) begin
                a_cnt++;
                if (a_cnt == 1) a_first = i; else a_second = i;
            end
        end
        check_eq("rereq_count", 32'(a_cnt), 32'd2);
        check_eq("rereq_first", 32'(a_first), 32'd2);
        check_eq("rereq_second", 32'(a_second), 32'd5);

        // Reset during the ACCESS cycle of an A store to 0x0C
        @(negedge clock);
        a_req = 1; a_we = 1; a_addr = 32'h0C; a_wdata = 32'hFFFF_FFFF;
        @(negedge clock);
        check_eq("rstmid_we_pre", 32'(mem_memWrite), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("rstmid_we", 32'(mem_memWrite), 32'd0);
        check_eq("rstmid_addr", mem_address, 32'd0);
        check_eq("rstmid_wdata", mem_writeData, 32'd0);
        check_eq("rstmid_grant", 32'(grant), 32'd0);
        check_eq("rstmid_rdata", a_rdata | b_rdata, 32'd0);
        a_req = 0;
        @(negedge clock);
        check_eq("rstmid_noack", 32'({a_ack, a_err}), 32'd0);
        reset_n = 1'b1;
        check_eq("rstmid_ram", ram[3], 32'hA000_0003);
        run_access("a_ld0c", 1'b0, 1'b0, 32'h0C, 32'h0, 32'hA000_0003, 1'b0);

        // Both ports request continuously from a fresh reset
        do_reset();
        a_req = 1; a_we = 0; a_addr = 32'h08;
        b_req = 1; b_we = 0; b_addr = 32'h08;
        a_cnt = 0; b_cnt = 0; a_first = 0; b_first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (a_ack) begin a_cnt++; if (a_first == 0) a_first = i; end
            if (b_ack) begin b_cnt++; if (b_first == 0) b_first = i; end
        end
        a_req = 0; b_req = 0;
        check_eq("cont_a_first", 32'(a_first), 32'd2);
`ifdef DATAMEM_ARB_RR_EN
        check_eq("cont_a_cnt", 32'(a_cnt), 32'd2);
        check_eq("cont_b_cnt", 32'(b_cnt), 32'd2);
        check_eq("cont_b_first", 32'(b_first), 32'd5);
`else
        check_eq("cont_a_cnt", 32'(a_cnt), 32'd4);
        check_eq("cont_b_cnt", 32'(b_cnt), 32'd0);
`endif

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter and access sequencer in front of the single-ported `datamem` word RAM. It accepts load/store requests from two requesters over a req/ack handshake: port A is the processor memory stage, port B is the debug/DMA loader. It grants one requester at a time and drives `datamem`'s address, writeData, memWrite and memRead for exactly one cycle per access. It registers the returned read data and flags misaligned addresses.

## Interface
- `ADDR_W`, 32: byte address width on both requester ports and the memory port.
- `DATA_W`, 32: data width.
- `clock`  in  1: rising-edge clock, shared with `datamem`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `a_req`  in  1: port A request; held with `a_we`, `a_addr` and `a_wdata` stable until `a_ack`.
- `a_we`  in  1: port A direction; 1 = store, 0 = load.
- `a_addr`  in  ADDR_W: port A byte address.
- `a_wdata`  in  DATA_W: port A store data.
- `a_ack`  out  1: one-cycle completion pulse to port A.
- `a_err`  out  1: valid with `a_ack`; 1 = misaligned access, which was suppressed.
- `a_rdata`  out  DATA_W: port A load data, valid with `a_ack`.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_err`, `b_rdata`: identical to port A, for port B.
- `mem_address`  out  ADDR_W: to `datamem` address.
- `mem_writeData`  out  DATA_W: to `datamem` writeData.
- `mem_memWrite`  out  1: to `datamem` memWrite.
- `mem_memRead`  out  1: to `datamem` memRead.
- `mem_readData`  in  DATA_W: from `datamem` readData, combinational from the address.
- `grant`  out  2: one-hot owner of the current access; bit0 = A, bit1 = B; 0 when idle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - All memory outputs are 0.
  - If any request is pending, select a winner and latch its we, addr and wdata.
  - Set `grant` and go to ACCESS.
  - If no request is pending, stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - `mem_address` is the latched address.
  - `mem_writeData` is the latched wdata.
  - `mem_memWrite` = we & aligned.
  - `mem_memRead` = ~we & aligned.
  - At the end-of-cycle edge, capture `mem_readData` into the winner's rdata register. Captured value is 0 for stores and for misaligned accesses.
  - Go to RESP.
- **RESP** (exactly 1 cycle)
  - Winner's ack = 1.
  - Winner's err = (addr[1:0] != 0).
  - Winner's rdata holds the captured value.
  - `grant` cleared at exit; go to IDLE.
- Aligned means addr[1:0] == 2'b00. A misaligned access never asserts memWrite or memRead.
- Handshake rules:
  - A requester drops req at the edge on which it samples ack high.
  - Req still high in the following IDLE cycle is a new request.
  - Req changes while not granted are legal. Req changes while granted are illegal; the latched values are used.
- Arbitration:
  - Decided only in IDLE.
  - A request from the non-winner stays pending and is considered on the next IDLE.
- `x_rdata` holds its last captured value until the next access by that port.
- `x_ack` and `x_err` are 0 outside RESP.
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs go to 0 immediately: ack, err, rdata, grant and every `mem_*` output.
  - An access in ACCESS is aborted and its write does not commit, because memWrite drops before the edge.
  - The in-flight requester receives no ack and must re-request.

## Timing
- Latency: req sampled high in IDLE at cycle n -> ACCESS in n+1 -> ack in n+2.
- Throughput: one access per 3 cycles. Back-to-back A then B gives ack A at n+2 and ack B at n+5.
- Stores commit to `datamem` at the rising edge ending ACCESS.
- `mem_readData` is sampled at that same edge. `datamem` read is combinational, so no extra wait cycle is needed.
- All outputs are registered; there is no combinational path from a requester port to any output.

## Configuration
- `DATAMEM_ARB_RR_EN` defined:
  - Round-robin arbitration. A `last` register records the most recent winner.
  - On a tie, the port that did not win last is granted.
  - `last` resets to B, so A wins the first tie.
- `DATAMEM_ARB_RR_EN` undefined:
  - Fixed priority; A always wins ties.
  - B can starve while A requests continuously.

## Test plan
- Reset, then A store addr 0x08 data 0xDEADBEEF:
  - memWrite=1 for exactly 1 cycle with mem_address 0x08.
  - a_ack at cycle +2 with a_err=0.
  - A follow-up A load of 0x08 returns a_rdata 0xDEADBEEF.
- A load addr 0x06 (misaligned):
  - memRead and memWrite stay 0.
  - a_ack with a_err=1 and a_rdata 0.
  - RAM contents unchanged.
- A and B request in the same cycle, held continuously:
  - With `DATAMEM_ARB_RR_EN`: grants alternate A, B, A, B at 3-cycle spacing.
  - Without it: only A is acked and B is never granted.
- B store 0x10=0x12345678 while A requests a load of 0x10 one cycle later: B completes first, and A then reads 0x12345678.
- reset_n asserted low mid-ACCESS of an A store to 0x0C=0xFFFFFFFF:
  - All outputs are 0 immediately; no ack is issued.
  - After release, a load of 0x0C returns its prior value.
- Requester keeps req high for one cycle after ack: treated as a new request, and a second ack follows 3 cycles after the first.
